src_mem_responder: RTL

//  Memory-side responder for the SRC CPU external bus: answers the CPU's
//  mem_bus/address/read/enable transactions with word reads and writes.
//  - Single-port word RAM with programmable wait states.
//  - Drives the shared 32-bit tri-state mem_bus only while returning read data.
//  - Debug peek port for benches; sits opposite the CPU's memory controller.

---
 rtl/src_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/src_mem_responder.sv
// src_mem_responder: memory-side responder for the SRC CPU external bus.
// Word RAM with programmable wait states; drives the shared tri-state mem_bus
// only while returning read data. Combinational debug peek port.
// Optional build macro SRC_MEM_BOUNDS_EN: out-of-range accesses are not
// wrapped (reads return 0, writes dropped, mem_err pulses); otherwise the
// address wraps modulo DEPTH and mem_err is tied low.
module src_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   inout  wire  [DATA_W-1:0] mem_bus,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              enable,
   output logic              mem_ready,
   output logic              mem_err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DRIVE, HOLD} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              read_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        cnt;
   logic              drive_en;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              capture;
   logic              resolve;
   logic [ADDR_W-1:0] req_addr;
   logic              req_read;
   logic [DATA_W-1:0] req_data;
   logic [IDX_W-1:0]  req_idx;
   logic              in_range;

   // Request view: with no wait states the access resolves on the capture
   // edge itself, so use the live inputs then, otherwise the latched copy.
   // Capture is gated by rst_n so nothing commits while reset is held.
   always_comb begin
      capture  = rst_n && (state == IDLE) && enable;
      req_addr = capture ? address : addr_q;
      req_read = capture ? read    : read_q;
      req_data = capture ? mem_bus : data_q;
      req_idx  = IDX_W'({1'b0, req_addr} % (ADDR_W+1)'(DEPTH));
`ifdef SRC_MEM_BOUNDS_EN
      in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
`else
      in_range = 1'b1;
`endif
      resolve  = (capture && (WAIT_CYCLES == 0)) ||
                 ((state == WAIT) && (cnt == 4'd0));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: a resolve with enable already low completes the access
   // silently and goes straight back to IDLE (nothing driven, no ready).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (capture) state_nxt = resolve ? (req_read ? DRIVE : HOLD) : WAIT;
         WAIT:        if (resolve) state_nxt = !enable ? IDLE : (read_q ? DRIVE : HOLD);
         DRIVE, HOLD: if (!enable) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Outputs derive from state so reset releases the bus immediately
   always_comb begin
      drive_en  = (state == DRIVE);
      mem_ready = (state == DRIVE) || (state == HOLD);
   end

   assign mem_bus = drive_en ? rdata_q : {DATA_W{1'bz}};

   // Request capture, wait counter and read-data fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         read_q  <= 1'b0;
         data_q  <= '0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         if (capture) begin
            addr_q <= address;
            read_q <= read;
            if (!read) data_q <= mem_bus;
         end
         if (capture && (WAIT_CYCLES > 0)) cnt <= 4'(WAIT_CYCLES - 1);
         else if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
         if (resolve && req_read) rdata_q <= in_range ? mem[req_idx] : '0;
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (resolve && !req_read && in_range) mem[req_idx] <= req_data;
   end

`ifdef SRC_MEM_BOUNDS_EN
   logic err_q;

   // One-cycle error pulse when an out-of-range access resolves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= resolve && !in_range;
   end

   assign mem_err = err_q;
`else
   assign mem_err = 1'b0;
`endif

   assign dbg_data = mem[IDX_W'({1'b0, dbg_addr} % (ADDR_W+1)'(DEPTH))];

endmodule
